// File: rtl/fir_ring_sequencer_if.sv
// Bus bundle of fir_ring_sequencer: sample input, RAM ports and MAC output.
// master = the sequencer itself, slave = its environment (source, RAM, MAC).
interface fir_ring_sequencer_if #(
  parameter int AW = 7,
  parameter int DW = 36
);
  logic          x_avail;
  logic [DW-1:0] x_data;
  logic          busy;
  logic          overrun;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddress;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_q;
  logic          mac_valid;
  logic [DW-1:0] mac_data;
  logic [AW-1:0] mac_tap;
  logic          mac_first;
  logic          mac_last;

  modport master (
    input  x_avail, x_data, ram_q,
    output busy, overrun, ram_wren, ram_wraddress, ram_data, ram_rdaddress,
           mac_valid, mac_data, mac_tap, mac_first, mac_last
  );

  modport slave (
    output x_avail, x_data, ram_q,
    input  busy, overrun, ram_wren, ram_wraddress, ram_data, ram_rdaddress,
           mac_valid, mac_data, mac_tap, mac_first, mac_last
  );
endinterface

// File: rtl/fir_ring_sequencer.sv
// Sample-history sequencer for the polyphase FIR. Clears the history RAM after
// reset, writes each accepted sample into a circular buffer, then replays the
// newest NTAPS samples (newest first) to the MAC with tap index and framing.
module fir_ring_sequencer #(
  parameter int AW    = 7,
  parameter int DW    = 36,
  parameter int NTAPS = 128,
  parameter int RDLAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  fir_ring_sequencer_if.master bus
);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, DRAIN} state_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [AW-1:0] tap;
  } tap_info_t;

  localparam logic [AW-1:0] MAX_ADDR   = {AW{1'b1}};
  localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);
  localparam logic [AW-1:0] LAST_DRAIN = AW'(RDLAT - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [AW-1:0] wptr, base;
  logic [AW-1:0] wr_hold, rd_hold;
  logic [DW-1:0] x_reg;
  logic          overrun;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  tap_info_t     pipe_in;
  tap_info_t     pipe [RDLAT];

  // State and phase counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; cnt walks RAM addresses in CLEAR, taps in READ, pipe stages in DRAIN.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no inferred latch).
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == MAX_ADDR) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      IDLE:  if (bus.x_avail) state_nx = WRITE;
      WRITE: begin
        state_nx = READ;
        cnt_nx   = '0;
      end
      READ: begin
        if (cnt == LAST_TAP) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  // RAM port and read-pipe stage-0 decode from the current state.
  always_comb begin
    wr_en   = (state == CLEAR) || (state == WRITE);
    wr_addr = wr_hold;
    wr_data = '0;
    rd_addr = rd_hold;
    pipe_in = '0;
    case (state)
      CLEAR: wr_addr = cnt;
      WRITE: begin
        wr_addr = wptr;
        wr_data = x_reg;
      end
      READ: begin
        rd_addr       = base - cnt;
        pipe_in.valid = 1'b1;
        pipe_in.tap   = cnt;
        pipe_in.first = (cnt == '0);
        pipe_in.last  = (cnt == LAST_TAP);
      end
      default: ;
    endcase
  end

  // Sample capture, write pointer, sticky overrun and held RAM addresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_reg   <= '0;
      wptr    <= '0;
      base    <= '0;
      overrun <= 1'b0;
      wr_hold <= '0;
      rd_hold <= '0;
    end else begin
      if (bus.x_avail && state == IDLE) x_reg <= bus.x_data;
      if (bus.x_avail && state != IDLE) overrun <= 1'b1;
      if (state == WRITE) begin
        base <= wptr;
        wptr <= wptr + 1'b1;
      end
      if (wr_en) wr_hold <= wr_addr;
      if (state == READ) rd_hold <= rd_addr;
    end
  end

  // Tap framing delayed RDLAT clocks so it lines up with ram_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this small array is reset on purpose so mac_valid drops the instant reset asserts.
      for (int i = 0; i < RDLAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.overrun       = overrun;
  assign bus.ram_wren      = wr_en & ~reset;
  assign bus.ram_wraddress = wr_addr;
  assign bus.ram_data      = wr_data;
  assign bus.ram_rdaddress = rd_addr;
  assign bus.mac_valid     = pipe[RDLAT-1].valid;
  assign bus.mac_tap       = pipe[RDLAT-1].tap;
  assign bus.mac_first     = pipe[RDLAT-1].first;
  assign bus.mac_last      = pipe[RDLAT-1].last;
  assign bus.mac_data      = bus.ram_q;

endmodule
